// File: rtl/datapath_seq_pkg.sv
// Shared opcodes, field positions, FSM states and decode bundle
// for the datapath sequencer.
package datapath_seq_pkg;

  localparam int PC_W_DEF = 8;

  localparam logic [2:0] ALU_ADD_DEF = 3'b000;
  localparam logic [2:0] ALU_SUB_DEF = 3'b001;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_J    = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int F_OP_HI  = 15;
  localparam int F_OP_LO  = 12;
  localparam int F_A_HI   = 11;
  localparam int F_A_LO   = 10;
  localparam int F_B_HI   = 9;
  localparam int F_B_LO   = 8;
  localparam int F_C_HI   = 7;
  localparam int F_C_LO   = 6;
  localparam int F_IMM_HI = 7;
  localparam int F_IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_WB,
    CL_MEM,
    CL_BEQ,
    CL_JMP,
    CL_NEXT,
    CL_HALT
  } iclass_t;

  typedef struct packed {
    logic [1:0] rd0;
    logic [1:0] rd1;
    logic [1:0] wr;
    logic       src1;
    logic       src2;
    logic [2:0] alu_op;
    logic [7:0] imm;
    logic       load;
    logic       ovf_chk;
  } ctrl_t;

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decoder: instruction register in,
// control bundle and execution class out.
module seq_decoder
  import datapath_seq_pkg::*;
#(
  parameter logic [2:0] ALU_ADD_OP = ALU_ADD_DEF,
  parameter logic [2:0] ALU_SUB_OP = ALU_SUB_DEF
) (
  input  logic [15:0] ir,
  output ctrl_t       ctrl,
  output iclass_t     iclass
);

  logic [3:0] op;
  logic [1:0] fa;
  logic [1:0] fb;
  logic [1:0] fc;

  assign op = ir[F_OP_HI:F_OP_LO];
  assign fa = ir[F_A_HI:F_A_LO];
  assign fb = ir[F_B_HI:F_B_LO];
  assign fc = ir[F_C_HI:F_C_LO];

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD_OP;
    ctrl.imm    = ir[F_IMM_HI:F_IMM_LO];
    iclass      = CL_NEXT;
    unique case (1'b1)
      !op[3]: begin
        ctrl.wr      = fa;
        ctrl.rd0     = fb;
        ctrl.rd1     = fc;
        ctrl.alu_op  = op[2:0];
        ctrl.ovf_chk = 1'b1;
        iclass       = CL_WB;
      end
      op == OP_ADDI: begin
        ctrl.wr      = fa;
        ctrl.rd0     = fb;
        ctrl.src2    = 1'b1;
        ctrl.ovf_chk = 1'b1;
        iclass       = CL_WB;
      end
      op == OP_LI: begin
        ctrl.wr   = fa;
        ctrl.src1 = 1'b1;
        ctrl.src2 = 1'b1;
        iclass    = CL_WB;
      end
      op == OP_LW: begin
        ctrl.wr   = fa;
        ctrl.rd0  = fb;
        ctrl.src2 = 1'b1;
        ctrl.load = 1'b1;
        iclass    = CL_MEM;
      end
      op == OP_SW: begin
        ctrl.rd0  = fb;
        ctrl.rd1  = fa;
        ctrl.src2 = 1'b1;
        iclass    = CL_MEM;
      end
      op == OP_BEQ: begin
        ctrl.rd0    = fb;
        ctrl.rd1    = fa;
        ctrl.alu_op = ALU_SUB_OP;
        iclass      = CL_BEQ;
      end
      op == OP_J:    iclass = CL_JMP;
      op == OP_HALT: iclass = CL_HALT;
      default:       iclass = CL_NEXT;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multicycle sequencer driving the 8-bit datapath control strobes.
// Optional overflow trap: define DATAPATH_SEQ_OVF_TRAP_EN.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int         PC_W       = PC_W_DEF,
  parameter logic [2:0] ALU_ADD_OP = ALU_ADD_DEF,
  parameter logic [2:0] ALU_SUB_OP = ALU_SUB_DEF
) (
  input  logic            clk,
  input  logic            rst_general_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            alu_zero,
  input  logic            alu_ovf,
  output logic            reg_wr,
  output logic            reg_rd,
  output logic [1:0]      rd0_addr,
  output logic [1:0]      rd1_addr,
  output logic [1:0]      wr_addr,
  output logic            alu_src1,
  output logic            alu_src2,
  output logic [2:0]      alu_op,
  output logic [7:0]      imm,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            busy,
  output logic            halted,
  output logic            trap,
  output logic [15:0]     retired
);

  state_t          state;
  state_t          state_nx;
  iclass_t         iclass;
  ctrl_t           ctrl;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;
  logic [15:0]     ir;
  logic            restart;
  logic            retire;
  logic            trap_hit;

  seq_decoder #(
    .ALU_ADD_OP(ALU_ADD_OP),
    .ALU_SUB_OP(ALU_SUB_OP)
  ) u_dec (
    .ir    (ir),
    .ctrl  (ctrl),
    .iclass(iclass)
  );

  assign restart = start & (state == S_IDLE || state == S_HALT);
  assign pc_inc  = pc + PC_W'(1);
  assign br_off  = PC_W'($signed(ctrl.imm));

`ifdef DATAPATH_SEQ_OVF_TRAP_EN
  assign trap_hit = (state == S_EXEC) & ctrl.ovf_chk & alu_ovf;

  always_ff @(posedge clk or negedge rst_general_n) begin
    if (!rst_general_n) trap <= 1'b0;
    else if (restart)   trap <= 1'b0;
    else if (trap_hit)  trap <= 1'b1;
  end
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf ^ ctrl.ovf_chk;
  assign trap_hit   = 1'b0;
  assign trap       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_general_n) begin
    if (!rst_general_n) state <= S_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_HALT: if (start) state_nx = S_FETCH;
      S_FETCH:        state_nx = S_DECODE;
      S_DECODE:       state_nx = S_EXEC;
      S_EXEC: begin
        unique case (iclass)
          CL_WB:   state_nx = trap_hit ? S_HALT : S_WB;
          CL_MEM:  state_nx = S_MEM;
          CL_HALT: state_nx = S_HALT;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEM:   state_nx = ctrl.load ? S_WB : S_FETCH;
      S_WB:    state_nx = S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  // A trapped R/ADDI never reaches WB, so pc and retired stay put.
  always_comb begin
    pc_nx  = pc;
    retire = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: if (start) pc_nx = '0;
      S_EXEC: begin
        unique case (iclass)
          CL_BEQ: begin
            pc_nx  = alu_zero ? pc_inc + br_off : pc_inc;
            retire = 1'b1;
          end
          CL_JMP: begin
            pc_nx  = PC_W'(ctrl.imm);
            retire = 1'b1;
          end
          CL_NEXT: begin
            pc_nx  = pc_inc;
            retire = 1'b1;
          end
          CL_HALT: retire = 1'b1;
          default: retire = 1'b0;
        endcase
      end
      S_MEM: begin
        if (!ctrl.load) begin
          pc_nx  = pc_inc;
          retire = 1'b1;
        end
      end
      S_WB: begin
        pc_nx  = pc_inc;
        retire = 1'b1;
      end
      default: pc_nx = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_general_n) begin
    if (!rst_general_n) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      pc <= pc_nx;
      if (state == S_DECODE) ir <= imem_data;
      if (retire) retired <= retired + 16'd1;
    end
  end

  always_comb begin
    reg_rd     = 1'b0;
    rd0_addr   = '0;
    rd1_addr   = '0;
    wr_addr    = '0;
    alu_src1   = 1'b0;
    alu_src2   = 1'b0;
    alu_op     = '0;
    imm        = '0;
    mem_write  = 1'b0;
    reg_wr     = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state)
      S_EXEC, S_MEM, S_WB: begin
        reg_rd   = 1'b1;
        rd0_addr = ctrl.rd0;
        rd1_addr = ctrl.rd1;
        wr_addr  = ctrl.wr;
        alu_src1 = ctrl.src1;
        alu_src2 = ctrl.src2;
        alu_op   = ctrl.alu_op;
        imm      = ctrl.imm;
        mem_write  = (state == S_MEM) & ~ctrl.load;
        reg_wr     = (state == S_WB);
        mem_to_reg = (state == S_WB) & ctrl.load;
      end
      default: reg_rd = 1'b0;
    endcase
  end

  assign imem_addr = pc;
  assign busy      = !(state == S_IDLE || state == S_HALT);
  assign halted    = (state == S_HALT);

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multicycle control unit that replaces the debug-probe control path and sits directly upstream of the 8-bit datapath (register file, 8-bit ALU with operand muxes, 9-bit data memory).
- Fetches 16-bit instructions from an external instruction ROM, decodes them, and drives every datapath control strobe cycle by cycle.
- Consumes the ALU zero/ovf flags for branching and for the optional overflow trap.

Parameters:
- PC_W, 8, program-counter and imem address width; PC wraps mod 2^PC_W.
- ALU_ADD_OP, 3'b000, alu_op code for address/immediate addition.
- ALU_SUB_OP, 3'b001, alu_op code used by BEQ compare.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_general_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins execution at PC 0 when in IDLE or HALT
- imem_addr  out  PC_W  instruction ROM address
- imem_data  in  16  ROM data, valid 1 cycle after imem_addr
- alu_zero  in  1  ALU zero flag
- alu_ovf  in  1  ALU overflow flag
- reg_wr  out  1  register file write enable
- reg_rd  out  1  register file read enable
- rd0_addr, rd1_addr, wr_addr  out  2 each  register addresses
- alu_src1  out  1  1 selects the constant zero as ALU operand A
- alu_src2  out  1  1 selects imm as ALU operand B
- alu_op  out  3  ALU function select
- imm  out  8  immediate operand
- mem_write  out  1  data memory write enable
- mem_to_reg  out  1  1 selects memory data as writeback
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- trap  out  1  overflow trap flag (only with OVF_TRAP_EN, else tied 0)
- retired  out  16  retired-instruction count, wraps at 0xFFFF

Behaviour:
- Instruction fields: op[15:12], a=[11:10], b=[9:8], c=[7:6], imm=[7:0].
- Opcodes:
  - 0xxx R-type: wr=a, rd0=b, rd1=c, alu_op=op[2:0].
  - 1000 ADDI: a <- b+imm.
  - 1001 LI: a <- 0+imm (alu_src1=1).
  - 1010 LW: a <- mem[b+imm].
  - 1011 SW: mem[b+imm] <- reg a (rd1=a).
  - 1100 BEQ: if reg b == reg a, pc <- pc+1+sext(imm); else pc <- pc+1.
  - 1101 J: pc <- imm[PC_W-1:0].
  - 1110 NOP.
  - 1111 HALT.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - IDLE/HALT --start--> FETCH with pc=0.
  - FETCH: drive imem_addr=pc.
  - DECODE: latch imem_data into the instruction register.
  - EXEC: drive rd addresses, reg_rd=1, mux selects, alu_op and imm; these are held stable through MEM and WB.
    - R/ADDI/LI -> WB.
    - LW/SW -> MEM.
    - BEQ/J/NOP -> FETCH, with pc updated at the end of EXEC.
    - HALT -> HALT.
  - MEM: mem_write=1 for exactly 1 cycle (SW -> FETCH); LW waits 1 cycle for memory data -> WB.
  - WB: reg_wr=1 for exactly 1 cycle, mem_to_reg=1 for LW only -> FETCH.
- PC increment: pc+1 at the WB/MEM exit for non-branch instructions.
- Latency, FETCH to next FETCH: R/ADDI/LI 4 cycles; SW 4; LW 5; BEQ/J/NOP 3.
- retired increments once per completed instruction, including HALT.
- Reset values: all enables 0, all addresses/imm/alu_op 0, mux selects 0, pc 0, retired 0, trap 0, state IDLE, busy 0, halted 0.
- Reset mid-operation aborts immediately; any in-flight reg_wr or mem_write is deasserted asynchronously.
- start while busy is ignored. start in HALT clears halted and trap and restarts at pc 0; retired is not cleared.
- Branch target arithmetic is mod 2^PC_W (wrap both directions).
- Only the control outputs listed for the current state are high; all other control outputs are 0.

Optional Feature:
- Macro DATAPATH_SEQ_OVF_TRAP_EN.
- Defined: an R-type or ADDI instruction with alu_ovf=1 sampled in EXEC suppresses its WB. The FSM goes to HALT with trap=1; retired is not incremented and pc holds the faulting address.
- Undefined: alu_ovf is ignored, the 9-bit {ovf,result} is written normally, and trap is constant 0.

Decomposition:
- Shared package datapath_seq_pkg holds:
  - opcode constants (OP_ADDI … OP_HALT);
  - the state enum;
  - field-position localparams;
  - ALU op defaults.
- One sub-module, seq_decoder: purely combinational, takes the instruction register and produces control bundle fields and next-state class. The FSM, pc and counters stay in datapath_sequencer.

Test Plan:
- Reset, then start; ROM[0]=LI a=1 imm=0x05 -> wr_addr=1, alu_src1=1, alu_src2=1, imm=0x05, reg_wr high exactly in cycle 4 after FETCH entry; retired=1.
- LW a=2 b=1 imm=0x03 -> MEM state 1 cycle with mem_write=0, then WB with mem_to_reg=1 and reg_wr=1; total 5 cycles.
- SW a=3 b=0 imm=0x10 -> rd1_addr=3, alu_op=ALU_ADD_OP, mem_write high for exactly 1 cycle, reg_wr never high.
- BEQ at pc=0x02 with imm=0xFC and alu_zero=1 -> next imem_addr=0xFF (wrap); with alu_zero=0 -> 0x03.
- HALT at pc=5 -> halted=1, busy=0, outputs idle. start -> imem_addr=0, halted=0. start pulsed while busy -> no effect.
- rst_general_n low during WB -> reg_wr drops in same cycle, state IDLE, pc 0. With DATAPATH_SEQ_OVF_TRAP_EN, ADD with alu_ovf=1 -> no reg_wr, trap=1, halted=1.
